// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM state type, MMIO addresses and width constants for dmem_responder
package dmem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int CNT_W          = 4;

  localparam logic [31:0] MMIO_TX_ADDR   = 32'h0000_0000;
  localparam logic [31:0] MMIO_HALT_ADDR = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with one synchronous byte-enabled write port and one combinational read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [BYTES_PER_WORD-1:0] wr_be,
  input  logic [AW-1:0]             index,
  input  logic [WORD_W-1:0]         wr_data,
  output logic [WORD_W-1:0]         rd_data
);

  // Contents are deliberately left unreset so software-visible data survives a reset.
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes; other lanes keep their old value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (wr_be[i]) begin
          mem[index][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_data = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder; optional MMIO tx/halt via DMEM_RESPONDER_MMIO_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
`ifdef DMEM_RESPONDER_MMIO_EN
  ,
  output logic        mmio_valid,
  output logic [31:0] mmio_data,
  output logic        halt
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [3:0]         be_q;
  logic [29:0]        word_q;
  logic [31:0]        wdata_q;
  logic               in_range;
  logic               mem_wr;
  logic [WORD_W-1:0]  mem_rdata;

  // Only the word index is kept; the byte offset within the word is irrelevant.
  assign in_range = ({2'b00, word_q} < 32'(DEPTH_WORDS));

  // State, wait counter and the captured request; capture happens only on acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        cnt_q   <= CNT_W'(WAIT_CYCLES);
        we_q    <= we;
        be_q    <= be;
        word_q  <= addr[31:2];
        wdata_q <= wdata;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Next state: requests outside IDLE are dropped, never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs; reset during RESP suppresses both the ack and the commit.
  always_comb begin
    ack    = (state_q == S_RESP) && !reset;
    err    = ack && !in_range;
    rdata  = (ack && in_range && !we_q) ? mem_rdata : '0;
    busy   = (state_q != S_IDLE);
    mem_wr = ack && we_q && in_range;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_wr),
    .wr_be   (be_q),
    .index   (word_q[AW-1:0]),
    .wr_data (wdata_q),
    .rd_data (mem_rdata)
  );

`ifdef DMEM_RESPONDER_MMIO_EN
  logic halt_q;

  // Halt is sticky once software stores to the halt address.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else if (ack && we_q && word_q == MMIO_HALT_ADDR[31:2]) begin
      halt_q <= 1'b1;
    end
  end

  assign halt       = halt_q;
  assign mmio_valid = ack && we_q && (word_q == MMIO_TX_ADDR[31:2]);
  assign mmio_data  = mmio_valid ? wdata_q : '0;
`endif

endmodule
